// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers used by the MixColumns sequencer.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mcs_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_columns_sequencer_if.sv
// Valid/ready stream bundle for the MixColumns sequencer: state in, mixed state out.
interface mix_columns_sequencer_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_state_t in_data;
  logic       in_bypass;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_data;
  logic       busy;

  modport slave (
    input  in_valid, in_data, in_bypass, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, in_bypass, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/mix_column_word.sv
// Combinational AES column mixer: four byte mixers on rotated views of one 32-bit column.
module mix_column_word
  import aes_pkg::*;
(
  input  aes_word_t col_i,
  output aes_word_t col_o
);

  function automatic logic [7:0] mix_byte(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    return xtime(a) ^ xtime(b) ^ b ^ c ^ d;
  endfunction

  // Row r sits at col[31-8r -: 8]; output row r takes 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3].
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;
    assign col_o[31-8*r -: 8] = mix_byte(col_i[31-8*r -: 8], col_i[31-8*R1 -: 8],
                                         col_i[31-8*R2 -: 8], col_i[31-8*R3 -: 8]);
  end

endmodule

// File: rtl/mix_columns_sequencer.sv
// AES MixColumns over a 128-bit state, LANES columns per cycle, mixed in place in a state buffer.
module mix_columns_sequencer
  import aes_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mix_columns_sequencer_if.slave  bus
);

  localparam logic [1:0] COL_STEP = 2'(LANES);
  localparam logic [1:0] LAST_COL = 2'(4 - LANES);

  mcs_state_e state_q, state_d;
  logic [1:0] col_q, col_d;
  aes_state_t buf_q, buf_d;

  aes_word_t  cols_q [4];
  aes_word_t  cols_d [4];
  aes_word_t  lane_in  [LANES];
  aes_word_t  lane_out [LANES];

  logic in_ready;
  logic accept;

  always_comb begin
    for (int c = 0; c < 4; c++) cols_q[c] = buf_q[127-32*c -: 32];
  end

  // Lane l works on column col+l; col is always a multiple of LANES so this never wraps.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = cols_q[col_q + 2'(l)];
    mix_column_word u_mix (
      .col_i (lane_in[l]),
      .col_o (lane_out[l])
    );
  end

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cols_d  = cols_q;
    buf_d   = buf_q;
    if (accept) begin
      buf_d   = bus.in_data;
      col_d   = 2'd0;
      state_d = bus.in_bypass ? ST_DONE : ST_BUSY;
    end else begin
      case (state_q)
        ST_BUSY: begin
          for (int c = 0; c < 4; c++) begin
            if (col_q == 2'(c - (c % LANES))) cols_d[c] = lane_out[c % LANES];
          end
          buf_d = {cols_d[0], cols_d[1], cols_d[2], cols_d[3]};
          col_d = col_q + COL_STEP;
          if (col_q == LAST_COL) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) state_d = ST_IDLE;
        end
        ST_IDLE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= 2'd0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_data  = buf_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mix_columns_sequencer.sv
// Bench for mix_columns_sequencer: vector table on LANES=1/2/4, then scoreboard-checked sequences on LANES=1.
module tb_mix_columns_sequencer;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mix_columns_sequencer_if bus1 ();
  mix_columns_sequencer_if bus2 ();
  mix_columns_sequencer_if bus4 ();

  assign bus2.in_valid  = bus1.in_valid;
  assign bus2.in_data   = bus1.in_data;
  assign bus2.in_bypass = bus1.in_bypass;
  assign bus2.out_ready = bus1.out_ready;
  assign bus4.in_valid  = bus1.in_valid;
  assign bus4.in_data   = bus1.in_data;
  assign bus4.in_bypass = bus1.in_bypass;
  assign bus4.out_ready = bus1.out_ready;

  mix_columns_sequencer #(.LANES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mix_columns_sequencer #(.LANES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  mix_columns_sequencer #(.LANES(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  logic [2:0] ov, rdy, bsy;
  aes_state_t od [3];
  assign ov  = {bus4.out_valid, bus2.out_valid, bus1.out_valid};
  assign rdy = {bus4.in_ready, bus2.in_ready, bus1.in_ready};
  assign bsy = {bus4.busy, bus2.busy, bus1.busy};
  assign od[0] = bus1.out_data;
  assign od[1] = bus2.out_data;
  assign od[2] = bus4.out_data;

  localparam aes_state_t V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam aes_state_t V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam aes_state_t V2_IN  = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
  localparam aes_state_t V2_OUT = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;

  int n_vec = 0;
  int n_err = 0;
  aes_state_t sb_q [$];
  bit mon_en = 1'b0;
  bit acc_flag = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] k);
    logic [7:0] p, a;
    p = 8'h00;
    a = x;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic aes_state_t ref_mix(input aes_state_t s, input logic byp);
    aes_state_t o;
    logic [7:0] b [4];
    o = s;
    if (!byp) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) b[r] = s[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++)
          o[127-8*(4*c+r) -: 8] = gmul(b[r], 8'd2) ^ gmul(b[(r+1)%4], 8'd3) ^ b[(r+2)%4] ^ b[(r+3)%4];
      end
    end
    return o;
  endfunction

  // Handshakes are judged at the falling edge, where every input and output is settled.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus1.in_valid && bus1.in_ready) begin
        sb_q.push_back(ref_mix(bus1.in_data, bus1.in_bypass));
        acc_flag = 1'b1;
      end
      if (bus1.out_valid && bus1.out_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got %h, want no output", bus1.out_data);
        end else begin
          chk("sb_data", bus1.out_data, sb_q.pop_front());
        end
      end
    end
  end

  task automatic send(input aes_state_t d, input logic byp);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    acc_flag = 1'b0;
    bus1.in_valid  = 1'b1;
    bus1.in_data   = d;
    bus1.in_bypass = byp;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (acc_flag) begin ok = 1'b1; break; end
    end
    bus1.in_valid = 1'b0;
    acc_flag = 1'b0;
    if (!ok) chk("send_timeout", 128'(ok), 128'd1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0 && !bus1.busy) begin ok = 1'b1; break; end
    end
    chk("drain_done", 128'(ok), 128'd1);
  endtask

  typedef struct {
    aes_state_t din;
    logic       byp;
    aes_state_t exp;
  } vec_t;

  vec_t tbl [6];
  int   lat [3];
  aes_state_t got [3];
  int   sent;
  int   cyc;

  initial begin
    tbl[0] = '{V1_IN, 1'b0, V1_OUT};
    tbl[1] = '{V2_IN, 1'b0, V2_OUT};
    tbl[2] = '{128'h0, 1'b0, 128'h0};
    tbl[3] = '{{128{1'b1}}, 1'b0, {128{1'b1}}};
    tbl[4] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 128'h00112233_44556677_8899aabb_ccddeeff};
    tbl[5] = '{V2_IN, 1'b1, V2_IN};

    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.in_bypass = 1'b0;
    bus1.out_ready = 1'b0;

    // Reset state on all three lane configurations
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", 128'(ov[d]), 128'd0);
      chk("rst_busy", 128'(bsy[d]), 128'd0);
      chk("rst_in_ready", 128'(rdy[d]), 128'd1);
      chk("rst_out_data", od[d], 128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Table: data and latency for each lane count
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus1.in_valid  = 1'b1;
      bus1.in_data   = tbl[i].din;
      bus1.in_bypass = tbl[i].byp;
      bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin lat[d] = 0; got[d] = '0; end
      for (int k = 1; k <= 8; k++) begin
        for (int d = 0; d < 3; d++) begin
          if (ov[d] && lat[d] == 0) begin lat[d] = k; got[d] = od[d]; end
        end
        @(posedge clk); #1;
      end
      for (int d = 0; d < 3; d++) begin
        int lanes;
        lanes = (d == 0) ? 1 : ((d == 1) ? 2 : 4);
        chk($sformatf("tbl%0d_L%0d_latency", i, lanes), 128'(lat[d]),
            tbl[i].byp ? 128'd1 : 128'(4 / lanes + 1));
        chk($sformatf("tbl%0d_L%0d_data", i, lanes), got[d], tbl[i].exp);
        chk($sformatf("tbl%0d_L%0d_idle", i, lanes), 128'(rdy[d]), 128'd1);
      end
    end

    // Backpressure in DONE, then back-to-back accept on release
    mon_en = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    acc_flag       = 1'b0;
    bus1.in_valid  = 1'b1;
    bus1.in_data   = V2_IN;
    bus1.in_bypass = 1'b0;
    @(posedge clk); #1;
    chk("bp_first_accept", 128'(acc_flag), 128'd1);
    acc_flag     = 1'b0;
    bus1.in_data = V1_IN;
    for (int k = 0; k < 10 && !bus1.out_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("bp_out_valid", 128'(bus1.out_valid), 128'd1);
    for (int k = 0; k < 10; k++) begin
      chk("bp_hold_data", bus1.out_data, V2_OUT);
      chk("bp_hold_in_ready", 128'(bus1.in_ready), 128'd0);
      @(posedge clk); #1;
    end
    chk("bp_no_extra_accept", 128'(acc_flag), 128'd0);
    chk("bp_queue_depth", 128'(sb_q.size()), 128'd1);
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_b2b_accept", 128'(acc_flag), 128'd1);
    chk("bp_b2b_busy", 128'(bus1.busy), 128'd1);
    chk("bp_b2b_out_valid", 128'(bus1.out_valid), 128'd0);
    bus1.in_valid = 1'b0;
    acc_flag = 1'b0;
    drain();

    // Asynchronous reset while BUSY at col=2
    mon_en = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    bus1.in_valid = 1'b1;
    bus1.in_data  = V1_IN;
    bus1.in_bypass = 1'b0;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_pre_col", 128'(u1.col_q), 128'd2);
    chk("arst_pre_busy", 128'(bus1.busy), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(bus1.out_valid), 128'd0);
    chk("arst_busy", 128'(bus1.busy), 128'd0);
    chk("arst_in_ready", 128'(bus1.in_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    send(V1_IN, 1'b0);
    drain();

    // Random stream against the reference model
    sent = 0;
    cyc  = 0;
    acc_flag = 1'b0;
    while ((sent < 1000 || sb_q.size() > 0 || bus1.in_valid) && cyc < 30000) begin
      @(posedge clk); #1;
      cyc++;
      if (acc_flag) begin
        bus1.in_valid = 1'b0;
        acc_flag = 1'b0;
      end
      if (!bus1.in_valid && sent < 1000 && $urandom_range(3) != 0) begin
        if (sent == 10)      bus1.in_data = '0;
        else if (sent == 20) bus1.in_data = {128{1'b1}};
        else                 bus1.in_data = {$urandom, $urandom, $urandom, $urandom};
        bus1.in_bypass = ($urandom_range(3) == 0);
        bus1.in_valid  = 1'b1;
        sent++;
      end
      bus1.out_ready = ($urandom_range(3) != 0);
    end
    chk("rand_timeout", 128'(cyc < 30000), 128'd1);
    chk("rand_queue_empty", 128'(sb_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
